// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus. It drives a one-hot gnt/oe and grants one cycle after req.
// Ownership ends on req release or after MAX_HOLD cycles, followed by TURN_CYCLES all-low cycles.
module tri_bus_arbiter #(
    parameter int NREQ        = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1,
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int HW = $clog2(MAX_HOLD + 1),
    localparam int TW = $clog2(TURN_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] oe,
    output logic [OW-1:0]   owner,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   last_q;
    logic [HW-1:0]   hold_q;
    logic [TW-1:0]   turn_q;

    logic            win_vld;
    logic [OW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic            arb_now;

    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return OW'(s);
    endfunction

    // Scan from the farthest offset down so the requester nearest last_q+1 is assigned last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[rr_idx(last_q, k)]) begin
                win_vld = 1'b1;
                win_idx = rr_idx(last_q, k);
            end
        end
        win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        arb_now = (state_q == IDLE) ||
                  ((state_q == TURN) && (turn_q == TW'(TURN_CYCLES)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            hold_q  <= '0;
            turn_q  <= '0;
        end else if (arb_now) begin
            turn_q <= '0;
            if (win_vld) begin
                state_q <= GRANT;
                gnt_q   <= win_oh;
                owner_q <= win_idx;
                last_q  <= win_idx;
                hold_q  <= HW'(1);
            end else begin
                state_q <= IDLE;
            end
        end else if (state_q == GRANT) begin
            if (req[owner_q] && (hold_q < HW'(MAX_HOLD))) begin
                hold_q <= hold_q + 1'b1;
            end else begin
                state_q <= TURN;
                gnt_q   <= '0;
                hold_q  <= '0;
                turn_q  <= TW'(1);
            end
        end else begin
            turn_q <= turn_q + 1'b1;
        end
    end

    assign gnt   = gnt_q;
    assign oe    = gnt_q;
    assign owner = owner_q;
    assign busy  = |gnt_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: vector table, directed rotation sequences, and a random run against a behavioural model.
module tb_tri_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req_a, gnt_a, oe_a;
    logic [1:0] owner_a;
    logic       busy_a;
    logic [3:0] req_b, gnt_b, oe_b;
    logic [1:0] owner_b;
    logic       busy_b;
    logic [2:0] req_c, gnt_c, oe_c;
    logic [1:0] owner_c;
    logic       busy_c;

    tri_bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURN_CYCLES(1)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .oe(oe_a), .owner(owner_a), .busy(busy_a));
    tri_bus_arbiter #(.NREQ(4), .MAX_HOLD(2), .TURN_CYCLES(2)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .oe(oe_b), .owner(owner_b), .busy(busy_b));
    tri_bus_arbiter #(.NREQ(3), .MAX_HOLD(3), .TURN_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .oe(oe_c), .owner(owner_c), .busy(busy_c));

    int errors = 0;
    int checks = 0;

    // Reference: current owner (-1 = none), cycles held, remaining turnaround cycles, last owner.
    typedef struct {
        int own;
        int held;
        int gap;
        int last;
    } mdl_t;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[18];

    function automatic mdl_t mdl_reset(input int n);
        mdl_t x;
        x.own = -1; x.held = 0; x.gap = 0; x.last = n - 1;
        return x;
    endfunction

    function automatic mdl_t mdl_arb(input mdl_t m, input logic [7:0] r, input int n);
        mdl_t x = m;
        x.own = -1;
        for (int k = 1; k <= n; k++) begin
            int i = (m.last + k) % n;
            if (r[i]) begin
                x.own = i; x.held = 1; x.last = i;
                return x;
            end
        end
        return x;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic [7:0] r, input int n,
                                      input int mh, input int tc);
        mdl_t x = m;
        if (m.own >= 0) begin
            if (r[m.own] && m.held < mh) x.held = m.held + 1;
            else begin x.own = -1; x.gap = tc; end
        end else if (m.gap > 1) begin
            x.gap = m.gap - 1;
        end else begin
            x.gap = 0;
            x = mdl_arb(x, r, n);
        end
        return x;
    endfunction

    function automatic int idx_of(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] g, input logic [7:0] o,
                           input logic [7:0] ow, input logic b, input logic [7:0] exp);
        chk({nm, " gnt"}, g, exp);
        chk({nm, " oe"}, o, exp);
        chk({nm, " busy"}, {7'b0, b}, {7'b0, (exp != 8'h0)});
        if (exp != 8'h0) chk({nm, " owner"}, ow, 8'(idx_of(exp)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        mdl_t       m;
        logic [7:0] expv;
        logic [2:0] prev_g;
        int         wait_c [3];
        int         zero_run, last_nz;
        logic       inv_ok, gap_ok, wait_ok;

        rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;

        // Reset/idle, reset mid-grant, early release, and a direct TURN->GRANT hand-off.
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b0, 4'b0010, 4'b0010};
        tbl[7]  = '{1'b0, 4'b0010, 4'b0010};
        tbl[8]  = '{1'b1, 4'b0010, 4'b0000};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0000};
        tbl[10] = '{1'b0, 4'b0110, 4'b0010};
        tbl[11] = '{1'b0, 4'b0110, 4'b0010};
        tbl[12] = '{1'b0, 4'b0110, 4'b0010};
        tbl[13] = '{1'b0, 4'b0100, 4'b0000};
        tbl[14] = '{1'b0, 4'b0100, 4'b0100};
        tbl[15] = '{1'b0, 4'b0100, 4'b0100};
        tbl[16] = '{1'b0, 4'b0000, 4'b0000};
        tbl[17] = '{1'b0, 4'b0001, 4'b0001};

        for (int i = 0; i < 18; i++) begin
            rst   = tbl[i].rst;
            req_a = tbl[i].req;
            step();
            chk_out($sformatf("vec%0d", i), {4'b0, gnt_a}, {4'b0, oe_a}, {6'b0, owner_a},
                    busy_a, {4'b0, tbl[i].exp});
        end
        rst = 1'b0;

        // Two requesters held: 0 for 8, gap, 2 for 8, gap, 0 again.
        do_reset();
        req_a = 4'b0101;
        for (int c = 1; c <= 19; c++) begin
            step();
            if (c <= 8)       expv = 8'h01;
            else if (c == 9)  expv = 8'h00;
            else if (c <= 17) expv = 8'h04;
            else if (c == 18) expv = 8'h00;
            else              expv = 8'h01;
            chk_out($sformatf("pair c%0d", c), {4'b0, gnt_a}, {4'b0, oe_a}, {6'b0, owner_a},
                    busy_a, expv);
        end

        // Lone requester is preempted at MAX_HOLD and re-granted after one gap cycle.
        do_reset();
        req_a = 4'b1000;
        for (int c = 1; c <= 20; c++) begin
            step();
            expv = (c == 9 || c == 18) ? 8'h00 : 8'h08;
            chk_out($sformatf("solo c%0d", c), {4'b0, gnt_a}, {4'b0, oe_a}, {6'b0, owner_a},
                    busy_a, expv);
        end

        // All four requesting, MAX_HOLD=2, TURN_CYCLES=2: 2 on, 2 off, rotating 0..3,0.
        do_reset();
        req_b = 4'b1111;
        for (int c = 1; c <= 18; c++) begin
            step();
            expv = (((c - 1) % 4) < 2) ? 8'(1 << (((c - 1) / 4) % 4)) : 8'h00;
            chk_out($sformatf("all c%0d", c), {4'b0, gnt_b}, {4'b0, oe_b}, {6'b0, owner_b},
                    busy_b, expv);
        end
        req_b = '0;

        // Random run on the 3-requester instance; requesters hold req until they own the bus.
        do_reset();
        m = mdl_reset(3);
        prev_g = '0; zero_run = 0; last_nz = -1;
        for (int i = 0; i < 3; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_c[i]) req_c[i] = ($urandom_range(0, 3) == 0);
                else if (m.own == i && $urandom_range(0, 3) == 0) req_c[i] = 1'b0;
            end
            step();
            m    = mdl_step(m, {5'b0, req_c}, 3, 3, 2);
            expv = (m.own >= 0) ? 8'(1 << m.own) : 8'h00;
            chk($sformatf("rand c%0d gnt", cyc), {5'b0, gnt_c}, expv);
            if (m.own >= 0) chk($sformatf("rand c%0d owner", cyc), {6'b0, owner_c}, 8'(m.own));

            inv_ok = ($countones(oe_c) <= 1) && (oe_c == gnt_c) && (busy_c == |gnt_c) &&
                     !((prev_g != 0) && (gnt_c != 0) && (gnt_c != prev_g));
            gap_ok = 1'b1;
            if (gnt_c != 0 && prev_g == 0 && last_nz >= 0 && idx_of({5'b0, gnt_c}) != last_nz)
                gap_ok = (zero_run >= 2);
            chk($sformatf("rand c%0d invariants", cyc), {6'b0, inv_ok, gap_ok}, 8'h03);

            wait_ok = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (gnt_c[i]) wait_c[i] = 0;
                else if (req_c[i]) wait_c[i]++;
                else wait_c[i] = 0;
                if (wait_c[i] > (3 - 1) * (3 + 2) + 2) wait_ok = 1'b0;
            end
            chk($sformatf("rand c%0d wait bound", cyc), {7'b0, wait_ok}, 8'h01);

            if (gnt_c == 0) zero_run++;
            else begin zero_run = 0; last_nz = idx_of({5'b0, gnt_c}); end
            prev_g = gnt_c;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
